count_checker: RTL and testbench

- Consumer end of the free-running counter interface: samples a `count` bus every cycle and checks it advances by exactly +1 modulo 2^WIDTH.
- Acquires lock after a run of consecutive good increments, then flags and counts each discontinuity.
- Captures the first failing expected/observed pair.
- Used as an in-design monitor on counter outputs and as a self-checking sink in counter test benches.

---
 rtl/count_checker.sv | 118 +++++++++++
 tb/tb_count_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// Consumer-side monitor for a free-running counter: locks onto a +1 sequence,
// then flags, counts and captures every discontinuity seen while locked.
module count_checker #(
    parameter int WIDTH       = 32,
    parameter int LOCK_CYCLES = 4,
    parameter int ERR_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     count,
    output logic                 locked,
    output logic                 error,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected,
    output logic [WIDTH-1:0]     first_err_exp,
    output logic [WIDTH-1:0]     first_err_got,
    output logic                 first_err_valid
);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        SYNC,
        TRACK
    } state_t;

    state_t                 state;
    logic [7:0]             run;
    logic [WIDTH-1:0]       count_inc;
    logic                   match;
    logic                   run_done;
    logic [ERR_WIDTH-1:0]   err_inc;

    always_comb begin
        count_inc = count + WIDTH'(1);
        match     = (count == expected);
        run_done  = (({1'b0, run} + 9'd1) == 9'(LOCK_CYCLES));
        err_inc   = (err_count == '1) ? err_count : err_count + ERR_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            run             <= '0;
            locked          <= 1'b0;
            error           <= 1'b0;
            err_count       <= '0;
            expected        <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            error <= 1'b0;

            // Clear is applied first so a coincident mismatch below overrides it.
            if (clear) begin
                err_count       <= '0;
                first_err_exp   <= '0;
                first_err_got   <= '0;
                first_err_valid <= 1'b0;
            end

            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
                run    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                    end

                    ACQUIRE: begin
                        expected <= count_inc;
                        run      <= '0;
                        state    <= SYNC;
                    end

                    SYNC: begin
                        expected <= count_inc;
                        if (!match) begin
                            run <= '0;
                        end else if (run_done) begin
                            run    <= '0;
                            locked <= 1'b1;
                            state  <= TRACK;
                        end else begin
                            run <= run + 8'd1;
                        end
                    end

                    TRACK: begin
                        expected <= count_inc;
                        if (!match) begin
                            error     <= 1'b1;
                            err_count <= clear ? ERR_WIDTH'(1) : err_inc;
                            if (clear || !first_err_valid) begin
                                first_err_exp   <= expected;
                                first_err_got   <= count;
                                first_err_valid <= 1'b1;
                            end
                            locked <= 1'b0;
                            run    <= '0;
                            state  <= SYNC;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: a behavioural model checked on every
// falling edge, plus literal expectations at key points of each scenario.
module tb_count_checker;

    localparam int W = 8;
    localparam int L = 4;
    localparam int E = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] count = '0;

    logic         locked, error, first_err_valid;
    logic [E-1:0] err_count;
    logic [W-1:0] expected, first_err_exp, first_err_got;

    logic         l1_locked, l1_error, l1_fv;
    logic [E-1:0] l1_err_count;
    logic [W-1:0] l1_expected, l1_fe, l1_fg;

    int total = 0;
    int bad   = 0;
    int c     = 0;
    int exp_v;

    always #5 clk = ~clk;

    count_checker #(.WIDTH(W), .LOCK_CYCLES(L), .ERR_WIDTH(E)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .count(count),
        .locked(locked), .error(error), .err_count(err_count), .expected(expected),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got),
        .first_err_valid(first_err_valid)
    );

    count_checker #(.WIDTH(W), .LOCK_CYCLES(1), .ERR_WIDTH(E)) dut_l1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .count(count),
        .locked(l1_locked), .error(l1_error), .err_count(l1_err_count),
        .expected(l1_expected), .first_err_exp(l1_fe), .first_err_got(l1_fg),
        .first_err_valid(l1_fv)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Behavioural model: phase flags instead of a state machine, integer arithmetic.
    bit m_init = 0, m_active = 0, m_seeded = 0, m_lock = 0, m_err = 0, m_fv = 0;
    int m_run = 0, m_exp = 0, m_errs = 0, m_fe = 0, m_fg = 0;

    always @(posedge clk) begin
        m_init = 1;
        if (!rst) begin
            m_active = 0; m_seeded = 0; m_lock = 0; m_err = 0; m_fv = 0;
            m_run = 0; m_exp = 0; m_errs = 0; m_fe = 0; m_fg = 0;
        end else begin
            m_err = 0;
            if (clear) begin
                m_errs = 0; m_fv = 0; m_fe = 0; m_fg = 0;
            end
            if (!enable) begin
                m_active = 0; m_seeded = 0; m_lock = 0; m_run = 0;
            end else if (!m_active) begin
                m_active = 1;
            end else if (!m_seeded) begin
                m_seeded = 1;
                m_run    = 0;
                m_exp    = (int'(count) + 1) % 256;
            end else begin
                if (int'(count) == m_exp) begin
                    if (!m_lock) begin
                        m_run = m_run + 1;
                        if (m_run == L) begin
                            m_lock = 1;
                            m_run  = 0;
                        end
                    end
                end else if (m_lock) begin
                    m_err  = 1;
                    m_errs = (m_errs + 1 > 15) ? 15 : m_errs + 1;
                    if (!m_fv) begin
                        m_fv = 1; m_fe = m_exp; m_fg = int'(count);
                    end
                    m_lock = 0;
                    m_run  = 0;
                end else begin
                    m_run = 0;
                end
                m_exp = (int'(count) + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("m_locked", locked, m_lock);
            chk("m_error", error, m_err);
            chk("m_err_count", err_count, m_errs);
            chk("m_expected", expected, m_exp);
            chk("m_first_exp", first_err_exp, m_fe);
            chk("m_first_got", first_err_got, m_fg);
            chk("m_first_valid", first_err_valid, m_fv);
        end
    end

    task automatic step(input bit r, input bit en, input bit cl, input int v);
        rst    = r;
        enable = en;
        clear  = cl;
        count  = v[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            c = (c + 1) % 256;
            step(1, 1, 0, c);
        end
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_expected", expected, 0);
        chk("rst_first_valid", first_err_valid, 0);

        // Acquire on 10, lock after 14
        step(1, 1, 0, 0);
        c = 10;
        step(1, 1, 0, c);
        chk("seed_expected", expected, 11);
        chk("l1_unlocked_after_seed", l1_locked, 0);
        feed(1);
        chk("l1_locks_first_match", l1_locked, 1);
        feed(2);
        chk("not_locked_after_13", locked, 0);
        feed(1);
        chk("locked_after_14", locked, 1);
        chk("expected_15", expected, 15);
        chk("no_error_acquire", err_count, 0);

        // Wrap 255 -> 0 while locked, end with expected=50
        while (c != 49) feed(1);
        chk("wrap_locked", locked, 1);
        chk("wrap_err_count", err_count, 0);
        chk("wrap_expected", expected, 50);

        // Discontinuity 50 -> 52
        c = 52;
        step(1, 1, 0, c);
        chk("mis_error", error, 1);
        chk("mis_err_count", err_count, 1);
        chk("mis_first_exp", first_err_exp, 50);
        chk("mis_first_got", first_err_got, 52);
        chk("mis_first_valid", first_err_valid, 1);
        chk("mis_unlocked", locked, 0);
        chk("mis_expected", expected, 53);
        feed(1);
        chk("error_one_cycle", error, 0);
        feed(2);
        chk("relock_not_yet", locked, 0);
        feed(1);
        chk("relock_after_56", locked, 1);

        // Saturation: 19 further locked mismatches
        for (int i = 0; i < 19; i++) begin
            c = (c + 5) % 256;
            step(1, 1, 0, c);
            feed(4);
        end
        chk("sat_err_count", err_count, 15);
        chk("sat_first_exp", first_err_exp, 50);
        chk("sat_first_got", first_err_got, 52);

        // Clear alone, then 7 events, then clear coincident with a mismatch
        c = (c + 1) % 256;
        step(1, 1, 1, c);
        chk("clear_err_count", err_count, 0);
        chk("clear_first_valid", first_err_valid, 0);
        chk("clear_keeps_lock", locked, 1);
        for (int i = 0; i < 7; i++) begin
            c = (c + 3) % 256;
            step(1, 1, 0, c);
            feed(4);
        end
        chk("seven_errors", err_count, 7);
        exp_v = (c + 1) % 256;
        c = (c + 9) % 256;
        step(1, 1, 1, c);
        chk("clr_mis_err_count", err_count, 1);
        chk("clr_mis_first_exp", first_err_exp, exp_v);
        chk("clr_mis_first_got", first_err_got, c);
        chk("clr_mis_valid", first_err_valid, 1);
        chk("clr_mis_error", error, 1);

        // Drop enable mid-TRACK, then reset with enable high
        feed(4);
        chk("pre_drop_locked", locked, 1);
        step(1, 0, 0, c);
        chk("drop_unlocked", locked, 0);
        chk("drop_keeps_errs", err_count, 1);
        step(0, 1, 0, c);
        chk("rst2_err_count", err_count, 0);
        chk("rst2_expected", expected, 0);
        chk("rst2_first_valid", first_err_valid, 0);
        step(1, 1, 0, 5);
        c = 77;
        step(1, 1, 0, c);
        chk("reacq_expected", expected, 78);
        chk("reacq_unlocked", locked, 0);
        chk("reacq_no_error", error, 0);
        feed(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
